// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash values,
// the sigma helper functions, and the message scheduler's state type.
package sha256_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Initial hash state, used by the compression core rather than the scheduler.
    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: loads a 16-word block, then streams the 64
// (Wt, Kt) round operands, expanding W16..W63 in place in a 16-entry ring.
module sha256_msg_scheduler
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort_i,
    input  logic [31:0] blk_word_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    output logic [31:0] wt_o,
    output logic [31:0] kt_o,
    output logic [5:0]  round_o,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic        first_o,
    output logic        last_o,
    output logic        done_o
);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wcnt;
    logic [5:0]  t;
    logic [31:0] ring [16];
    logic [3:0]  idx;
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [31:0] w_exp;
    logic [31:0] w_cur;
    logic        word_fire;
    logic        round_fire;

    // Ring slots holding W[t-2], W[t-7], W[t-15] and W[t-16]; the 4-bit sums wrap mod 16.
    assign idx     = t[3:0];
    assign idx_m2  = idx + 4'd14;
    assign idx_m7  = idx + 4'd9;
    assign idx_m15 = idx + 4'd1;

    assign w_exp = ssig1(ring[idx_m2]) + ring[idx_m7] + ssig0(ring[idx_m15]) + ring[idx];
    assign w_cur = (t < 6'd16) ? ring[idx] : w_exp;

    assign round_o = t;
    assign kt_o    = K[t];
    assign first_o = w_valid_o && (t == 6'd0);
    assign last_o  = w_valid_o && (t == 6'd63);

    // An abort cancels any handshake presented in the same cycle.
    assign word_fire  = blk_valid_i && blk_ready_o && !abort_i;
    assign round_fire = w_valid_o && w_ready_i && !abort_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; all outputs depend on registered state only.
    always_comb begin
        next_state  = state;
        blk_ready_o = 1'b0;
        w_valid_o   = 1'b0;
        done_o      = 1'b0;
        wt_o        = 32'h0;
        case (state)
            LOAD: begin
                blk_ready_o = 1'b1;
                if (blk_valid_i && (wcnt == 4'd15)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                w_valid_o = 1'b1;
                wt_o      = w_cur;
                if (w_ready_i && (t == 6'd63)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
        if (abort_i) begin
            next_state = LOAD;
        end
    end

    // Word/round counters and the ring: loads words, then overwrites each slot with its expanded W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
            t    <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                ring[i] <= 32'h0;
            end
        end else if (abort_i) begin
            wcnt <= 4'd0;
            t    <= 6'd0;
        end else begin
            if (word_fire) begin
                ring[wcnt] <= blk_word_i;
                wcnt       <= wcnt + 4'd1;
                if (wcnt == 4'd15) begin
                    t <= 6'd0;
                end
            end
            if (round_fire) begin
                if (t >= 6'd16) begin
                    ring[idx] <= w_cur;
                end
                t <= t + 6'd1;
            end
            if (state == DONE) begin
                wcnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Testbench for sha256_msg_scheduler: a FIPS 180-4 reference model fills a
// scoreboard of expected rounds; a negedge monitor checks every transfer.
module tb_sha256_msg_scheduler;

    typedef logic [31:0] block_t [16];

    typedef struct {
        logic [5:0]  round;
        logic [31:0] wt;
        logic [31:0] kt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        abort_i;
    logic [31:0] blk_word_i;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic [31:0] wt_o;
    logic [31:0] kt_o;
    logic [5:0]  round_o;
    logic        w_valid_o;
    logic        w_ready_i;
    logic        first_o;
    logic        last_o;
    logic        done_o;

    int          errors;
    int          checks;
    int          transfers;
    int          cyc;
    bit          ready_mode;
    bit          abc_mode;
    exp_t        sb [$];
    logic [31:0] kref [64];
    bit          stalled_prev;
    logic [5:0]  snap_round;
    logic [31:0] snap_wt;
    logic [31:0] snap_kt;

    sha256_msg_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .abort_i     (abort_i),
        .blk_word_i  (blk_word_i),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .wt_o        (wt_o),
        .kt_o        (kt_o),
        .round_o     (round_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .first_o     (first_o),
        .last_o      (last_o),
        .done_o      (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, or ready with 50% probability in stall mode.
    initial begin
        w_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready_i = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    function automatic void check_output(input string name, input logic [31:0] actual,
                                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endfunction

    function automatic logic [31:0] ref_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Round constants derived from first principles: first 32 fraction bits of cube roots of the first 64 primes.
    function automatic void compute_k();
        int          cnt;
        int          p;
        bit          prime;
        logic [127:0] target;
        logic [127:0] y;
        logic [127:0] cand;
        cnt = 0;
        p   = 2;
        while (cnt < 64) begin
            prime = 1'b1;
            for (int d = 2; d * d <= p; d++) begin
                if (p % d == 0) prime = 1'b0;
            end
            if (prime) begin
                target = 128'(p) << 96;
                y      = '0;
                for (int b = 35; b >= 0; b--) begin
                    cand = y | (128'd1 << b);
                    if (cand * cand * cand <= target) y = cand;
                end
                kref[cnt] = y[31:0];
                cnt++;
            end
            p++;
        end
    endfunction

    // Reference model: full 64-word expansion straight from the FIPS recurrence.
    function automatic void push_expected(input block_t blk);
        logic [31:0] w [64];
        logic [31:0] s0;
        logic [31:0] s1;
        exp_t        e;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            s0   = ref_rotr(w[i-15], 7) ^ ref_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ref_rotr(w[i-2], 17) ^ ref_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) begin
            e.round = 6'(i);
            e.wt    = w[i];
            e.kt    = kref[i];
            sb.push_back(e);
        end
    endfunction

    task automatic check_reset_values();
        check_output("reset blk_ready", 32'(blk_ready_o), 32'd1);
        check_output("reset w_valid", 32'(w_valid_o), 32'd0);
        check_output("reset first", 32'(first_o), 32'd0);
        check_output("reset last", 32'(last_o), 32'd0);
        check_output("reset done", 32'(done_o), 32'd0);
        check_output("reset round", 32'(round_o), 32'd0);
        check_output("reset wt", wt_o, 32'h0);
        check_output("reset kt", kt_o, 32'h428a2f98);
    endtask

    // Queue the expected rounds and feed the 16 words; optionally insert idle gaps.
    task automatic apply_stimulus(input block_t blk, input bit gapped, output int first_cyc);
        bit accepted;
        int budget;
        first_cyc = -1;
        transfers = 0;
        push_expected(blk);
        for (int i = 0; i < 16; i++) begin
            if (gapped && $urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                    blk_valid_i = 1'b0;
                    blk_word_i  = $urandom;
                    @(posedge clk);
                    #1;
                    check_output("w_valid low during load", 32'(w_valid_o), 32'd0);
                end
            end
            budget = 0;
            do begin
                blk_valid_i = 1'b1;
                blk_word_i  = blk[i];
                accepted    = blk_ready_o;
                if (accepted && i == 0) first_cyc = cyc;
                @(posedge clk);
                #1;
                budget++;
            end while (!accepted && budget < 100);
            if (!accepted) begin
                errors++;
                $display("[TB] FAIL word accept timeout: word %0d not taken", i);
                blk_valid_i = 1'b0;
                return;
            end
        end
        blk_valid_i = 1'b0;
        check_output("w_valid after 16th word", 32'(w_valid_o), 32'd1);
        check_output("first after 16th word", 32'(first_o), 32'd1);
    endtask

    task automatic wait_done(output int done_cyc);
        int budget;
        budget   = 0;
        done_cyc = -1;
        while (!done_o && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!done_o) begin
            errors++;
            $display("[TB] FAIL done timeout: done_o=%0b, expected 1", done_o);
            return;
        end
        done_cyc = cyc;
        check_output("done blk_ready", 32'(blk_ready_o), 32'd0);
        check_output("done w_valid", 32'(w_valid_o), 32'd0);
        check_output("rounds transferred", 32'(transfers), 32'd64);
        check_output("scoreboard drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_round(input int n);
        int budget;
        budget = 0;
        while (!(w_valid_o && round_o == 6'(n)) && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!(w_valid_o && round_o == 6'(n))) begin
            errors++;
            $display("[TB] FAIL round wait timeout: round_o=%0d, expected %0d", round_o, n);
        end
    endtask

    // Monitor: check every round transfer against the scoreboard and stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && w_valid_o) begin
            if (stalled_prev) begin
                check_output("stall hold round", 32'(round_o), 32'(snap_round));
                check_output("stall hold wt", wt_o, snap_wt);
                check_output("stall hold kt", kt_o, snap_kt);
            end
            if (w_ready_i && !abort_i) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected round: round_o=%0d, expected none", round_o);
                end else begin
                    e = sb.pop_front();
                    check_output("round", 32'(round_o), 32'(e.round));
                    check_output("wt", wt_o, e.wt);
                    check_output("kt", kt_o, e.kt);
                    check_output("first", 32'(first_o), 32'(e.round == 6'd0));
                    check_output("last", 32'(last_o), 32'(e.round == 6'd63));
                    if (abc_mode) begin
                        case (e.round)
                            6'd0: begin
                                check_output("abc w0", wt_o, 32'h61626380);
                                check_output("abc k0", kt_o, 32'h428a2f98);
                            end
                            6'd16: check_output("abc w16", wt_o, 32'h61626380);
                            6'd17: check_output("abc w17", wt_o, 32'h000f0000);
                            6'd63: begin
                                check_output("abc k63", kt_o, 32'hc67178f2);
                                check_output("abc last63", 32'(last_o), 32'd1);
                            end
                            default: ;
                        endcase
                    end
                end
                transfers++;
            end
            stalled_prev = !w_ready_i;
            snap_round   = round_o;
            snap_wt      = wt_o;
            snap_kt      = kt_o;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    initial begin
        block_t abc;
        block_t rnd;
        int     c0;
        int     cd;
        errors       = 0;
        checks       = 0;
        transfers    = 0;
        cyc          = 0;
        ready_mode   = 1'b0;
        abc_mode     = 1'b0;
        stalled_prev = 1'b0;
        rst_n        = 1'b0;
        abort_i      = 1'b0;
        blk_valid_i  = 1'b0;
        blk_word_i   = 32'h0;
        compute_k();
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        #2;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // "abc" block, consumer always ready; done_o lands in the 81st cycle of the block.
        $display("[TB] abc block, no stalls");
        abc_mode = 1'b1;
        apply_stimulus(abc, 1'b0, c0);
        wait_done(cd);
        check_output("done latency", 32'(cd - c0), 32'd80);
        @(posedge clk);
        #1;
        check_output("blk_ready after done", 32'(blk_ready_o), 32'd1);

        $display("[TB] abc block, random stalls");
        ready_mode = 1'b1;
        apply_stimulus(abc, 1'b0, c0);
        wait_done(cd);
        abc_mode = 1'b0;

        $display("[TB] back-to-back random blocks");
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        apply_stimulus(rnd, 1'b0, c0);
        wait_done(cd);
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        apply_stimulus(rnd, 1'b0, c0);
        wait_done(cd);

        $display("[TB] gapped input");
        ready_mode = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        apply_stimulus(rnd, 1'b1, c0);
        wait_done(cd);

        $display("[TB] abort at round 30");
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        apply_stimulus(rnd, 1'b0, c0);
        wait_round(30);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        sb.delete();
        check_output("abort w_valid", 32'(w_valid_o), 32'd0);
        check_output("abort blk_ready", 32'(blk_ready_o), 32'd1);
        check_output("abort round", 32'(round_o), 32'd0);
        abc_mode = 1'b1;
        apply_stimulus(abc, 1'b0, c0);
        wait_done(cd);

        $display("[TB] reset at round 40");
        abc_mode = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        apply_stimulus(rnd, 1'b0, c0);
        wait_round(40);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        sb.delete();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        abc_mode = 1'b1;
        apply_stimulus(abc, 1'b0, c0);
        wait_done(cd);
        abc_mode = 1'b0;

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
